// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one downstream memory/L2 port between NUM_PORTS upstream requesters
// (port 0 = instruction fetch, port 1 = data access, higher ports = prefetch etc).
// Only one access is outstanding at a time. The winner is picked either
// round-robin (RR_MODE=1) or by fixed priority, lowest index first (RR_MODE=0).
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   req_read/write   per-port request strobes, held until that port's req_resp
//   req_addr/wdata   per-port address / write data, port i at [i*W +: W]
//   req_mbe          per-port byte enables (writes)
//   req_resp         one-cycle completion pulse to the granted port
//   req_rdata        read data, straight from mem_rdata
//   mem_*            registered downstream request, held stable while busy
//   mem_resp         downstream completion, read data valid in the same cycle
//   grant_id         index of the port that currently owns the memory
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and launch at the next edge
// BUSY  | access in flight; mem_* frozen until mem_resp completes it
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RR_MODE   = 1,
    localparam int GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BW       = DW / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req_read,
    input  logic [NUM_PORTS-1:0]    req_write,
    input  logic [NUM_PORTS*AW-1:0] req_addr,
    input  logic [NUM_PORTS*DW-1:0] req_wdata,
    input  logic [NUM_PORTS*BW-1:0] req_mbe,
    output logic [NUM_PORTS-1:0]    req_resp,
    output logic [DW-1:0]           req_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic [BW-1:0]           mem_mbe,
    input  logic                    mem_resp,
    input  logic [DW-1:0]           mem_rdata,
    output logic [GW-1:0]           grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          ptr_nx;
    logic [NUM_PORTS-1:0]   active;
    logic                   win_found;
    logic [GW-1:0]          win_idx;
    logic [GW:0]            idx_ext;
    logic                   sel_write;
    logic [AW-1:0]          sel_addr;
    logic [DW-1:0]          sel_wdata;
    logic [BW-1:0]          sel_mbe;
    logic                   launch;
    logic                   complete;

    assign active = req_read | req_write;

    // Walk the ports starting at the pointer (or at 0 for fixed priority);
    // the extra index bit lets ptr+k exceed NUM_PORTS before the wrap subtract.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_ext   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                idx_ext = {1'b0, rr_ptr} + (GW+1)'(k);
                if (idx_ext >= (GW+1)'(NUM_PORTS)) begin
                    idx_ext = idx_ext - (GW+1)'(NUM_PORTS);
                end
            end else begin
                idx_ext = (GW+1)'(k);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!win_found && (idx_ext == (GW+1)'(i)) && active[i]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(i);
                end
            end
        end
    end

    // Payload of the winning port. A port asking for both read and write
    // launches the write; its read stays pending for a later arbitration.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_mbe   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == GW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_mbe   = req_mbe[i*BW +: BW];
            end
        end
    end

    always_comb begin
        if (grant_id == GW'(NUM_PORTS - 1)) begin
            ptr_nx = '0;
        end else begin
            ptr_nx = grant_id + GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and completion. mem_resp outside BUSY is simply ignored.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        complete = 1'b0;
        req_resp = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    launch   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_resp[i] = complete && (grant_id == GW'(i));
        end
    end

    assign req_rdata = mem_rdata;

    // Downstream request register: loaded on launch, frozen while busy,
    // strobes cleared on completion. Address/data keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mbe   <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (launch) begin
            mem_read  <= ~sel_write;
            mem_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_mbe   <= sel_mbe;
            grant_id  <= win_idx;
        end else if (complete) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (RR_MODE != 0) begin
                rr_ptr <= ptr_nx;
            end
        end
    end

endmodule
